// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write bank.
//   REG_COUNT  : number of architectural registers (register 0 reads as zero)
//   ADDR_W     : width of a register index
//   wb_state_t : write-bank sequencer states (normal writes / bulk clear)
package regfile_pkg;

    localparam int REG_COUNT = 32;
    localparam int ADDR_W    = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } wb_state_t;

endpackage

// File: rtl/decoder_5_to_32.sv
// One-hot address decoder.
//   ena : decode enable; when low every output bit is 0
//   in  : register index
//   out : one-hot select, bit 'in' set when ena is high
module decoder_5_to_32
    import regfile_pkg::*;
(
    input  logic                 ena,
    input  logic [ADDR_W-1:0]    in,
    output logic [REG_COUNT-1:0] out
);

    always_comb begin
        out = '0;
        if (ena) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_bank32.sv
// Write side and storage of the 32-entry register file.
// Accepts one write per cycle over a valid/ready port, holds the registers,
// drives every register in parallel to the read muxes, and can zero the whole
// bank with a sequenced clear (one register per cycle, indices 1..31).
//   clk, rst_n           : clock (rising edge), synchronous active-low reset
//   wr_valid/wr_ready    : write handshake; ready is high only when not clearing
//   wr_addr, wr_data     : destination index and data
//   wr_ack               : one-cycle pulse the cycle after a write is accepted
//   clear_req            : start a bulk clear (only looked at in IDLE)
//   busy                 : clear in progress
//   clear_done           : high during the final clear cycle
//   q00..q31             : register contents; q00 is constant zero
module regfile_write_bank32
    import regfile_pkg::*;
#(
    parameter int N = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [N-1:0]      wr_data,
    output logic              wr_ack,
    input  logic              clear_req,
    output logic              busy,
    output logic              clear_done,
    output logic [N-1:0]      q00, q01, q02, q03, q04, q05, q06, q07,
    output logic [N-1:0]      q08, q09, q10, q11, q12, q13, q14, q15,
    output logic [N-1:0]      q16, q17, q18, q19, q20, q21, q22, q23,
    output logic [N-1:0]      q24, q25, q26, q27, q28, q29, q30, q31
);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(REG_COUNT - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

    wb_state_t             state, state_next;
    logic [ADDR_W-1:0]     clr_idx, clr_idx_next;
    logic                  wr_accept;
    logic [REG_COUNT-1:0]  wr_en;
    logic [REG_COUNT-1:0]  clear_en;
    logic [N-1:0]          q_r [1:REG_COUNT-1];

    // Register 0 has no storage, so its decode bits go nowhere.
    logic unused_dec0;
    assign unused_dec0 = wr_en[0] ^ clear_en[0];

    assign wr_ready   = (state == IDLE);
    assign busy       = (state == CLEAR);
    assign clear_done = busy && (clr_idx == LAST_IDX);
    assign wr_accept  = wr_valid & wr_ready;

    decoder_5_to_32 u_wr_dec (
        .ena (wr_accept),
        .in  (wr_addr),
        .out (wr_en)
    );

    decoder_5_to_32 u_clr_dec (
        .ena (busy),
        .in  (clr_idx),
        .out (clear_en)
    );

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            clr_idx <= FIRST_IDX;
            wr_ack  <= 1'b0;
        end else begin
            state   <= state_next;
            clr_idx <= clr_idx_next;
            wr_ack  <= wr_accept;
        end
    end

    // Next state: clear_req is only honoured in IDLE; a clear always runs to
    // index 31, so the index increment never wraps.
    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next   = CLEAR;
                    clr_idx_next = FIRST_IDX;
                end
            end
            CLEAR: begin
                if (clr_idx == LAST_IDX) begin
                    state_next   = IDLE;
                    clr_idx_next = FIRST_IDX;
                end else begin
                    clr_idx_next = clr_idx + ADDR_W'(1);
                end
            end
            default: begin
                state_next   = IDLE;
                clr_idx_next = FIRST_IDX;
            end
        endcase
    end

    // Register storage. wr_en and clear_en are never both set for one index
    // because writes are refused while clearing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < REG_COUNT; i++) begin
                q_r[i] <= '0;
            end
        end else begin
            for (int i = 1; i < REG_COUNT; i++) begin
                if (clear_en[i]) begin
                    q_r[i] <= '0;
                end else if (wr_en[i]) begin
                    q_r[i] <= wr_data;
                end
            end
        end
    end

    assign q00 = '0;
    assign q01 = q_r[1];
    assign q02 = q_r[2];
    assign q03 = q_r[3];
    assign q04 = q_r[4];
    assign q05 = q_r[5];
    assign q06 = q_r[6];
    assign q07 = q_r[7];
    assign q08 = q_r[8];
    assign q09 = q_r[9];
    assign q10 = q_r[10];
    assign q11 = q_r[11];
    assign q12 = q_r[12];
    assign q13 = q_r[13];
    assign q14 = q_r[14];
    assign q15 = q_r[15];
    assign q16 = q_r[16];
    assign q17 = q_r[17];
    assign q18 = q_r[18];
    assign q19 = q_r[19];
    assign q20 = q_r[20];
    assign q21 = q_r[21];
    assign q22 = q_r[22];
    assign q23 = q_r[23];
    assign q24 = q_r[24];
    assign q25 = q_r[25];
    assign q26 = q_r[26];
    assign q27 = q_r[27];
    assign q28 = q_r[28];
    assign q29 = q_r[29];
    assign q30 = q_r[30];
    assign q31 = q_r[31];

endmodule

// File: tb/tb_regfile_write_bank32.sv
module tb_regfile_write_bank32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        wr_ack;
    logic        clear_req = 1'b0;
    logic        busy;
    logic        clear_done;
    logic [31:0] dq [32];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_write_bank32 #(.N(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .clear_req(clear_req), .busy(busy), .clear_done(clear_done),
        .q00(dq[0]),  .q01(dq[1]),  .q02(dq[2]),  .q03(dq[3]),
        .q04(dq[4]),  .q05(dq[5]),  .q06(dq[6]),  .q07(dq[7]),
        .q08(dq[8]),  .q09(dq[9]),  .q10(dq[10]), .q11(dq[11]),
        .q12(dq[12]), .q13(dq[13]), .q14(dq[14]), .q15(dq[15]),
        .q16(dq[16]), .q17(dq[17]), .q18(dq[18]), .q19(dq[19]),
        .q20(dq[20]), .q21(dq[21]), .q22(dq[22]), .q23(dq[23]),
        .q24(dq[24]), .q25(dq[25]), .q26(dq[26]), .q27(dq[27]),
        .q28(dq[28]), .q29(dq[29]), .q30(dq[30]), .q31(dq[31])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the bank as an array, plus "clear in progress" and
    // which register the clear zeroes next.
    logic [31:0] m_q [32];
    bit          m_clearing = 0;
    int          m_next_clr = 1;
    bit          m_ack = 0;
    bit          m_live = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            foreach (m_q[i]) m_q[i] = '0;
            m_clearing = 0;
            m_next_clr = 1;
            m_ack      = 0;
            m_live     = 1;
        end else begin
            m_ack = wr_valid && !m_clearing;
            if (m_clearing) begin
                m_q[m_next_clr] = '0;
                if (m_next_clr == 31) begin
                    m_clearing = 0;
                    m_next_clr = 1;
                end else begin
                    m_next_clr = m_next_clr + 1;
                end
            end else begin
                if (wr_valid && wr_addr != 0) m_q[wr_addr] = wr_data;
                if (clear_req) begin
                    m_clearing = 1;
                    m_next_clr = 1;
                end
            end
        end
    end

    // Compare process: every cycle once reset has been seen.
    always @(negedge clk) begin
        if (m_live) begin
            chk("wr_ready",   {31'd0, wr_ready},   {31'd0, !m_clearing});
            chk("busy",       {31'd0, busy},       {31'd0, m_clearing});
            chk("wr_ack",     {31'd0, wr_ack},     {31'd0, m_ack});
            chk("clear_done", {31'd0, clear_done}, {31'd0, (m_clearing && m_next_clr == 31)});
            for (int i = 0; i < 32; i++) chk($sformatf("q%0d", i), dq[i], m_q[i]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        cyc();
        wr_valid = 1'b0;
    endtask

    // Runs until busy drops (bounded); returns clear length and the cycle
    // number on which clear_done appeared (0 if never).
    task automatic run_clear(output int len, output int done_at);
        int guard;
        len = 0; done_at = 0; guard = 0;
        while (busy === 1'b1 && guard < 40) begin
            len++;
            if (clear_done === 1'b1) done_at = len;
            chk("ready_low_in_clear", {31'd0, wr_ready}, 32'd0);
            cyc();
            guard++;
        end
        if (guard >= 40) chk("clear_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int len, done_at, seen_done;
        logic [31:0] held;

        // 1. Reset with pre-written contents
        cyc(); cyc();
        rst_n = 1'b1;
        wr(5'd4, 32'h1234_5678);
        wr(5'd30, 32'hCAFE_F00D);
        chk("prewrite_q04", dq[4], 32'h1234_5678);
        rst_n = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        chk("rst_q04", dq[4], 32'd0);
        chk("rst_q30", dq[30], 32'd0);
        chk("rst_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ack", {31'd0, wr_ack}, 32'd0);

        // 2. Single write, latency 1, ack next cycle
        wr(5'd7, 32'hDEAD_BEEF);
        chk("w7_q07", dq[7], 32'hDEAD_BEEF);
        chk("w7_ack", {31'd0, wr_ack}, 32'd1);
        chk("w7_q06", dq[6], 32'd0);
        cyc();
        chk("w7_ack_drop", {31'd0, wr_ack}, 32'd0);

        // 3. R0 is hardwired, then a full burst with no stalls
        wr(5'd0, 32'hFFFF_FFFF);
        chk("r0_ack", {31'd0, wr_ack}, 32'd1);
        chk("r0_q00", dq[0], 32'd0);
        for (int i = 1; i < 32; i++) begin
            wr_valid = 1'b1; wr_addr = 5'(i); wr_data = 32'(100 + i);
            chk("burst_ready", {31'd0, wr_ready}, 32'd1);
            cyc();
        end
        wr_valid = 1'b0;
        chk("burst_q01", dq[1], 32'd101);
        chk("burst_q17", dq[17], 32'd117);
        chk("burst_q31", dq[31], 32'd131);

        // 4. Bulk clear with a write held across it
        for (int i = 1; i < 32; i++) wr(5'(i), $urandom | 32'h1);
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        held = 32'hA5A5_0009;
        wr_valid = 1'b1; wr_addr = 5'd9; wr_data = held;
        run_clear(len, done_at);
        chk("clear_len", 32'(len), 32'd31);
        chk("clear_done_at", 32'(done_at), 32'd31);
        chk("after_clear_q09", dq[9], 32'd0);
        chk("after_clear_q31", dq[31], 32'd0);
        chk("after_clear_ready", {31'd0, wr_ready}, 32'd1);
        cyc();
        wr_valid = 1'b0;
        chk("held_q09", dq[9], held);
        chk("held_ack", {31'd0, wr_ack}, 32'd1);

        // 5. Write and clear request in the same cycle
        clear_req = 1'b1;
        wr(5'd3, 32'h55);
        clear_req = 1'b0;
        chk("coll_ack", {31'd0, wr_ack}, 32'd1);
        chk("coll_q03_c1", dq[3], 32'h55);
        cyc();
        chk("coll_ack_once", {31'd0, wr_ack}, 32'd0);
        chk("coll_q03_c2", dq[3], 32'h55);
        cyc();
        chk("coll_q03_c3", dq[3], 32'h55);
        cyc();
        chk("coll_q03_zero", dq[3], 32'd0);
        run_clear(len, done_at);
        chk("coll_len", 32'(len), 32'd28);

        // 6. Reset in the middle of a clear
        for (int i = 1; i < 32; i++) wr(5'(i), 32'h1000 + 32'(i));
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        seen_done = 0;
        for (int c = 1; c < 10; c++) begin
            if (clear_done === 1'b1) seen_done = 1;
            cyc();
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("midrst_no_done", 32'(seen_done), 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_q25", dq[25], 32'd0);
        chk("midrst_q11", dq[11], 32'd0);
        wr(5'd20, 32'h77);
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        run_clear(len, done_at);
        chk("reclear_len", 32'(len), 32'd31);
        chk("reclear_done_at", 32'(done_at), 32'd31);

        // 7. Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            wr_valid  = ($urandom_range(0, 3) != 0);
            wr_addr   = 5'($urandom_range(0, 31));
            wr_data   = $urandom;
            clear_req = ($urandom_range(0, 39) == 0);
            rst_n     = ($urandom_range(0, 149) != 0);
            cyc();
        end
        wr_valid = 1'b0; clear_req = 1'b0; rst_n = 1'b1;
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
